// File: rtl/cmp_scan_pkg.sv
// Shared definitions for the frame extrema scanner: FSM state encoding,
// default sample width / frame length, and the index-width helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package cmp_scan_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a 0-based sample position within a frame; never below 1 bit.
  function automatic int idx_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/cmp_scan_ctrl_mag_cmp.sv
// mag_cmp: unsigned WIDTH-bit magnitude comparator, a against b.
// Latency: purely combinational. Backpressure: none.
// Ports: a, b (operands); g = a>b, l = a<b, e = a==b (exactly one is high).
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             g,
  output logic             l,
  output logic             e
);

  assign g = (a > b);
  assign l = (a < b);
  assign e = (a == b);

endmodule

// File: rtl/cmp_scan_ctrl.sv
// cmp_scan_ctrl: scans a LEN-sample frame, reporting running max/min with a done pulse.
// Latency: start at edge k -> LOAD at k+1; last accept at edge k+LEN (no stalls) -> done and results at that edge.
// Backpressure: in_ready high only in LOAD/SCAN; a source stall (in_valid=0) holds all state.
// Ports: clk/rst (async active-high); start, abort; in_valid/in_ready/in_data sample stream;
//   busy (LOAD/SCAN/DONE), done (1-cycle pulse), max_out/min_out (held until next completed frame).
// Optional: CMP_SCAN_IDX_EN adds max_idx/min_idx, first-occurrence position of each extreme.
module cmp_scan_ctrl
  import cmp_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN   = DEF_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        max_out,
  output logic [WIDTH-1:0]        min_out
`ifdef CMP_SCAN_IDX_EN
  ,
  output logic [idx_w(LEN)-1:0]   max_idx,
  output logic [idx_w(LEN)-1:0]   min_idx
`endif
);

  localparam int CW = $clog2(LEN + 1);
  localparam int IW = idx_w(LEN);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] wmax;
  logic [WIDTH-1:0] wmin;

  logic mx_g, mx_l, mx_e;
  logic mn_g, mn_l, mn_e;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a (in_data),
    .b (wmax),
    .g (mx_g),
    .l (mx_l),
    .e (mx_e)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a (in_data),
    .b (wmin),
    .g (mn_g),
    .l (mn_l),
    .e (mn_e)
  );

  // Only G of the max compare and L of the min compare steer updates;
  // ties (E) deliberately keep the earlier sample.
  logic unused_cmp;
  assign unused_cmp = mx_l ^ mx_e ^ mn_g ^ mn_e;

  assign in_ready = (state == LOAD) || (state == SCAN);
  assign busy     = (state != IDLE);

  // abort wins over a sample presented in the same cycle.
  logic accept;
  assign accept = in_valid & in_ready & ~abort;

  // The first sample of a frame (LOAD) loads both extremes unconditionally.
  logic             upd_max, upd_min;
  logic [WIDTH-1:0] nxt_max, nxt_min;
  logic [CW-1:0]    count_nxt;
  logic             last;

  assign upd_max   = (state == LOAD) || mx_g;
  assign upd_min   = (state == LOAD) || mn_l;
  assign nxt_max   = upd_max ? in_data : wmax;
  assign nxt_min   = upd_min ? in_data : wmin;
  assign count_nxt = count + CW'(1);
  // count is 0 in LOAD, so this also covers LEN==1 (LOAD straight to DONE).
  assign last      = (count_nxt == CW'(LEN));

`ifdef CMP_SCAN_IDX_EN
  logic [IW-1:0] wmax_idx, wmin_idx;
  logic [IW-1:0] nxt_max_idx, nxt_min_idx;
  logic [IW-1:0] pos;

  // Position of the sample being accepted is the count before increment.
  assign pos         = count[IW-1:0];
  assign nxt_max_idx = upd_max ? pos : wmax_idx;
  assign nxt_min_idx = upd_min ? pos : wmin_idx;
`endif

  // Results are captured on the edge that enters DONE, so they are already
  // valid during the done cycle and equal the working values held in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wmax     <= '0;
      wmin     <= '0;
      done     <= 1'b0;
      max_out  <= '0;
      min_out  <= '0;
`ifdef CMP_SCAN_IDX_EN
      wmax_idx <= '0;
      wmin_idx <= '0;
      max_idx  <= '0;
      min_idx  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            count <= '0;
          end
        end
        LOAD, SCAN: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            wmax  <= nxt_max;
            wmin  <= nxt_min;
            count <= count_nxt;
`ifdef CMP_SCAN_IDX_EN
            wmax_idx <= nxt_max_idx;
            wmin_idx <= nxt_min_idx;
`endif
            if (last) begin
              state   <= DONE;
              done    <= 1'b1;
              max_out <= nxt_max;
              min_out <= nxt_min;
`ifdef CMP_SCAN_IDX_EN
              max_idx <= nxt_max_idx;
              min_idx <= nxt_min_idx;
`endif
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Bench for cmp_scan_ctrl: LEN=8 main instance plus a LEN=1 instance.
// Expected extrema are pushed when a frame's last sample is driven and
// popped when done is observed.
module tb_cmp_scan_ctrl;

  localparam int W = 4;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LEN=8 instance
  logic         start = 0, abort = 0, in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, busy, done;
  logic [W-1:0] max_out, min_out;
  // LEN=1 instance
  logic         start1 = 0, abort1 = 0, in_valid1 = 0;
  logic [W-1:0] in_data1 = '0;
  logic         in_ready1, busy1, done1;
  logic [W-1:0] max_out1, min_out1;
`ifdef CMP_SCAN_IDX_EN
  logic [2:0] max_idx, min_idx;
  logic [0:0] max_idx1, min_idx1;
`endif

  cmp_scan_ctrl #(.WIDTH(W), .LEN(L)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .max_out(max_out), .min_out(min_out)
`ifdef CMP_SCAN_IDX_EN
    , .max_idx(max_idx), .min_idx(min_idx)
`endif
  );

  cmp_scan_ctrl #(.WIDTH(W), .LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .busy(busy1), .done(done1), .max_out(max_out1), .min_out(min_out1)
`ifdef CMP_SCAN_IDX_EN
    , .max_idx(max_idx1), .min_idx(min_idx1)
`endif
  );

  typedef struct {
    logic [W-1:0] mx;
    logic [W-1:0] mn;
    int           mxi;
    int           mni;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;
  logic [W-1:0] fr [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, want);
    end
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_width", done, 0);
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("max_out", max_out, mon_e.mx);
          chk("min_out", min_out, mon_e.mn);
          chk("done_cycle", cyc, mon_e.cyc);
`ifdef CMP_SCAN_IDX_EN
          chk("max_idx", max_idx, mon_e.mxi);
          chk("min_idx", min_idx, mon_e.mni);
`endif
        end
      end
      prev_done = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int k);
    start = 1'b1;
    step();
    k = cyc;
    start = 1'b0;
  endtask

  // Present one sample and wait for its accept edge; returns that edge number.
  task automatic send(input logic [W-1:0] d, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  function automatic exp_t model(input logic [W-1:0] s [8]);
    exp_t e;
    e.mx = s[0]; e.mn = s[0]; e.mxi = 0; e.mni = 0; e.cyc = 0;
    for (int i = 1; i < 8; i++) begin
      if (s[i] > e.mx) begin e.mx = s[i]; e.mxi = i; end
      if (s[i] < e.mn) begin e.mn = s[i]; e.mni = i; end
    end
    return e;
  endfunction

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    step();
  endtask

  task automatic run_frame(input logic [W-1:0] s [8], input int gap);
    exp_t e;
    int   k, acc;
    e = model(s);
    pulse_start(k);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (gap) step();
      send(s[i], acc);
    end
    // Back-to-back frames have a fixed latency from the start edge.
    e.cyc = (gap == 0) ? (k + L) : acc;
    sb.push_back(e);
    wait_drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, acc, ds;
    exp_t e;

    // Reset and idle: valid held high without start.
    in_valid = 1'b1;
    in_data  = 4'h7;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready", in_ready, 0);
      chk("idle_max", max_out, 0);
      chk("idle_min", min_out, 0);
    end
    chk("idle_no_done", done_seen, 0);
    in_valid = 1'b0;
    step();

    // LEN=1 instance: single sample frame.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = 4'hA;
    @(negedge clk);
    chk("len1_ready", in_ready1, 1);
    step();
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("len1_done", done1, 1);
    chk("len1_max", max_out1, 4'hA);
    chk("len1_min", min_out1, 4'hA);
`ifdef CMP_SCAN_IDX_EN
    chk("len1_max_idx", max_idx1, 0);
    chk("len1_min_idx", min_idx1, 0);
`endif
    step();
    @(negedge clk);
    chk("len1_done_pulse", done1, 0);
    step();

    // Basic frame.
    fr = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd0, 4'd7, 4'd9, 4'd2};
    run_frame(fr, 0);
    chk("basic_seen", done_seen, 1);

    // Abort with a third sample in the abort cycle.
    pulse_start(k);
    send(4'd4, acc);
    send(4'd6, acc);
    in_valid = 1'b1;
    in_data  = 4'd1;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    ds = done_seen;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_max", max_out, 15);
    chk("abort_min", min_out, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_seen, ds);
    step();

    // Ties with 3-cycle stalls between samples.
    fr = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    ds = done_seen;
    run_frame(fr, 3);
    chk("ties_one_done", done_seen, ds + 1);

    // Random frames, back-to-back and stalled.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) fr[i] = W'($urandom_range(0, 15));
      run_frame(fr, r);
    end

    // Start pulsed during SCAN is ignored; count keeps going.
    fr = '{4'd8, 4'd2, 4'd11, 4'd6, 4'd14, 4'd1, 4'd3, 4'd12};
    e = model(fr);
    pulse_start(k);
    for (int i = 0; i < 3; i++) send(fr[i], acc);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 3; i < 8; i++) send(fr[i], acc);
    e.cyc = k + L + 1;
    sb.push_back(e);
    wait_drain();

    // Reset in the middle of a frame.
    pulse_start(k);
    for (int i = 0; i < 4; i++) send(W'(i + 3), acc);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_max", max_out, 0);
    chk("midrst_min", min_out, 0);
    chk("midrst_max1", max_out1, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Fresh frame after reset.
    fr = '{4'd7, 4'd13, 4'd13, 4'd4, 4'd2, 4'd9, 4'd2, 4'd10};
    run_frame(fr, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
